// File: rtl/out_port_sched.sv
`default_nettype none
// ============================================================================
// Module      : out_port_sched
// Description : Output-port scheduler for N input buffers. Starvation-aware,
//               QoS-classed round-robin arbitration with zero-cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
module out_port_sched #(
    parameter int N       = 7,
    parameter int AGE_W   = 4,
    parameter int AGE_MAX = 15,
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     qos,
    input  logic             out_rdy,
    output logic [N-1:0]     gnt,
    output logic             gnt_vld,
    output logic [IDX_W-1:0] gnt_idx,
    output logic [N-1:0]     starved
);

    logic [AGE_W-1:0] age_q [N];
    logic [AGE_W-1:0] age_d [N];
    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] rr_ptr_d;

    logic [N-1:0]     w_cls_starved;
    logic [N-1:0]     w_cls_hi;
    logic [N-1:0]     w_cls_lo;
    logic [N-1:0]     w_cand;
    logic             w_found;
    logic [IDX_W-1:0] w_win_idx;
    logic [IDX_W-1:0] w_scan;

    for (genvar i = 0; i < N; i++) begin : g_starved
        assign starved[i] = (age_q[i] == AGE_W'(AGE_MAX));
    end

    assign w_cls_starved = req & starved;
    assign w_cls_hi      = req & ~starved & qos;
    assign w_cls_lo      = req & ~starved & ~qos;

    // Only the highest non-empty class competes.
    always_comb begin
        w_cand = w_cls_lo;
        if (|w_cls_starved) begin
            w_cand = w_cls_starved;
        end else if (|w_cls_hi) begin
            w_cand = w_cls_hi;
        end
    end

    // Upward search from the shared pointer, wrapping N-1 -> 0.
    always_comb begin
        w_found   = 1'b0;
        w_win_idx = '0;
        w_scan    = rr_ptr_q;
        for (int k = 0; k < N; k++) begin
            if (!w_found && w_cand[w_scan]) begin
                w_found   = 1'b1;
                w_win_idx = w_scan;
            end
            w_scan = (w_scan == IDX_W'(N - 1)) ? '0 : w_scan + IDX_W'(1);
        end
    end

    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        if (!rst && out_rdy && w_found) begin
            gnt[w_win_idx] = 1'b1;
            gnt_vld        = 1'b1;
            gnt_idx        = w_win_idx;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_vld) begin
            rr_ptr_d = (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + IDX_W'(1);
        end
    end

    // Ages only move on a real transfer, so back-pressure never counts as a loss.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            age_d[i] = age_q[i];
            if (!req[i] || gnt[i]) begin
                age_d[i] = '0;
            end else if (gnt_vld && (age_q[i] != AGE_W'(AGE_MAX))) begin
                age_d[i] = age_q[i] + AGE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            for (int i = 0; i < N; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int i = 0; i < N; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_out_port_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_out_port_sched
// Description : Self-checking bench for out_port_sched (directed + random).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_out_port_sched;

    localparam int N       = 7;
    localparam int AGE_W   = 4;
    localparam int AGE_MAX = 15;
    localparam int IDX_W   = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req = '0;
    logic [N-1:0]     qos = '0;
    logic             out_rdy = 1'b0;
    logic [N-1:0]     gnt;
    logic             gnt_vld;
    logic [IDX_W-1:0] gnt_idx;
    logic [N-1:0]     starved;

    out_port_sched #(.N(N), .AGE_W(AGE_W), .AGE_MAX(AGE_MAX)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .qos     (qos),
        .out_rdy (out_rdy),
        .gnt     (gnt),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx),
        .starved (starved)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         cs;
        logic [N-1:0] es;
        logic [N-1:0] eg;
    } exp_t;

    exp_t  sb[$];
    string tag_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    bit    mon_en = 1'b0;

    // Reference model state for the random phase
    int m_age [N];
    int m_ptr;

    function automatic logic [IDX_W-1:0] idx_of(input logic [N-1:0] g);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) if (g[i]) r = IDX_W'(i);
        return r;
    endfunction

    function automatic int class_of(input int i, input logic [N-1:0] qs);
        if (m_age[i] == AGE_MAX) return 2;
        return qs[i] ? 1 : 0;
    endfunction

    function automatic logic [N-1:0] model_gnt(input logic r, input logic [N-1:0] rq,
                                               input logic [N-1:0] qs, input logic rdy);
        logic [N-1:0] g;
        int best;
        g    = '0;
        best = -1;
        if (r || !rdy) return g;
        for (int i = 0; i < N; i++)
            if (rq[i] && class_of(i, qs) > best) best = class_of(i, qs);
        if (best < 0) return g;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (g == '0 && rq[i] && class_of(i, qs) == best) g[i] = 1'b1;
        end
        return g;
    endfunction

    task automatic model_update(input logic r, input logic [N-1:0] rq, input logic [N-1:0] g);
        if (r) begin
            m_ptr = 0;
            for (int i = 0; i < N; i++) m_age[i] = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!rq[i] || g[i]) m_age[i] = 0;
                else if (g != '0 && m_age[i] < AGE_MAX) m_age[i] = m_age[i] + 1;
            end
            if (g != '0) m_ptr = (int'(idx_of(g)) + 1) % N;
        end
    endtask

    task automatic check_out();
        exp_t  e;
        string t;
        e = sb.pop_front();
        t = tag_q.pop_front();
        n_cmp++;
        assert (gnt === e.eg) else begin
            n_err++;
            $error("FAIL %s gnt: observed %b expected %b", t, gnt, e.eg);
        end
        n_cmp++;
        assert (gnt_vld === (e.eg != '0)) else begin
            n_err++;
            $error("FAIL %s gnt_vld: observed %b expected %b", t, gnt_vld, (e.eg != '0));
        end
        n_cmp++;
        assert (gnt_idx === idx_of(e.eg)) else begin
            n_err++;
            $error("FAIL %s gnt_idx: observed %0d expected %0d", t, gnt_idx, idx_of(e.eg));
        end
        if (e.cs) begin
            n_cmp++;
            assert (starved === e.es) else begin
                n_err++;
                $error("FAIL %s starved: observed %b expected %b", t, starved, e.es);
            end
        end
    endtask

    task automatic step(input string tag, input logic r, input logic [N-1:0] rq,
                        input logic [N-1:0] qs, input logic rdy,
                        input logic [N-1:0] eg, input logic cs, input logic [N-1:0] es);
        @(posedge clk);
        #1;
        rst     = r;
        req     = rq;
        qos     = qs;
        out_rdy = rdy;
        sb.push_back('{cs, es, eg});
        tag_q.push_back(tag);
        @(negedge clk);
        check_out();
    endtask

    // Protocol invariants and the bounded-wait guarantee, every cycle
    int wait_cnt [N];
    always @(negedge clk) begin
        if (mon_en) begin
            int mx;
            n_cmp++;
            assert ($onehot0(gnt)) else begin
                n_err++;
                $error("FAIL mon_onehot: observed %b expected one-hot or zero", gnt);
            end
            n_cmp++;
            assert (gnt_vld === (|gnt)) else begin
                n_err++;
                $error("FAIL mon_vld: observed %b expected %b", gnt_vld, |gnt);
            end
            n_cmp++;
            assert ((gnt & ~req) === '0) else begin
                n_err++;
                $error("FAIL mon_noreq: observed gnt %b with req %b", gnt, req);
            end
            n_cmp++;
            assert (out_rdy === 1'b1 || gnt === '0) else begin
                n_err++;
                $error("FAIL mon_bp: observed gnt %b expected 0 with out_rdy=0", gnt);
            end
            mx = 0;
            for (int i = 0; i < N; i++) begin
                if (rst || !req[i] || gnt[i]) wait_cnt[i] = 0;
                else if (out_rdy) wait_cnt[i] = wait_cnt[i] + 1;
                if (wait_cnt[i] > mx) mx = wait_cnt[i];
            end
            n_cmp++;
            assert (mx <= N * (AGE_MAX + 1)) else begin
                n_err++;
                $error("FAIL mon_wait: observed %0d cycles expected <= %0d", mx, N * (AGE_MAX + 1));
            end
        end
    end

    initial begin
        logic [N-1:0] rq_r;
        logic [N-1:0] qs_r;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;

        // Reset: outputs gated while rst is high, starved cleared after the edge
        step("rst0", 1'b1, 7'h7F, 7'h00, 1'b1, 7'h00, 1'b0, 7'h00);
        step("rst1", 1'b1, 7'h7F, 7'h00, 1'b1, 7'h00, 1'b1, 7'h00);
        mon_en = 1'b1;

        // Round-robin with wrap-around
        step("rr0",     1'b0, 7'b1000001, 7'h00, 1'b1, 7'b0000001, 1'b1, 7'h00);
        step("rr6",     1'b0, 7'b1000001, 7'h00, 1'b1, 7'b1000000, 1'b1, 7'h00);
        step("rr_wrap", 1'b0, 7'b1000001, 7'h00, 1'b1, 7'b0000001, 1'b1, 7'h00);

        // QoS class wins until the low class starves
        step("rst2", 1'b1, 7'h00, 7'h00, 1'b1, 7'h00, 1'b0, 7'h00);
        for (int k = 0; k < 15; k++)
            step("cls_hi", 1'b0, 7'b0000111, 7'b0000100, 1'b1, 7'b0000100, 1'b1, 7'h00);
        step("starv0",    1'b0, 7'b0000111, 7'b0000100, 1'b1, 7'b0000001, 1'b1, 7'b0000011);
        step("starv1",    1'b0, 7'b0000111, 7'b0000100, 1'b1, 7'b0000010, 1'b1, 7'b0000010);
        step("starv_clr", 1'b0, 7'b0000111, 7'b0000100, 1'b1, 7'b0000100, 1'b1, 7'h00);

        // Back-pressure: nothing granted, nothing ages, pointer held at 3
        for (int k = 0; k < 20; k++)
            step("bp", 1'b0, 7'h7F, 7'h00, 1'b0, 7'h00, 1'b1, 7'h00);
        step("bp_rel3", 1'b0, 7'h7F, 7'h00, 1'b1, 7'b0001000, 1'b1, 7'h00);
        step("bp_rel4", 1'b0, 7'h7F, 7'h00, 1'b1, 7'b0010000, 1'b1, 7'h00);
        step("bp_rel5", 1'b0, 7'h7F, 7'h00, 1'b1, 7'b0100000, 1'b1, 7'h00);
        step("bp_rel6", 1'b0, 7'h7F, 7'h00, 1'b1, 7'b1000000, 1'b1, 7'h00);
        step("bp_rel0", 1'b0, 7'h7F, 7'h00, 1'b1, 7'b0000001, 1'b1, 7'h00);
        step("bp_rel1", 1'b0, 7'h7F, 7'h00, 1'b1, 7'b0000010, 1'b1, 7'h00);
        step("bp_rel2", 1'b0, 7'h7F, 7'h00, 1'b1, 7'b0000100, 1'b1, 7'h00);

        // Mid-run reset with age[3]=9 and rr_ptr=5
        step("rst3", 1'b1, 7'h00, 7'h00, 1'b1, 7'h00, 1'b0, 7'h00);
        for (int k = 0; k < 9; k++)
            step("mid_build", 1'b0, 7'b0011000, 7'b0010000, 1'b1, 7'b0010000, 1'b1, 7'h00);
        step("mid_rst",   1'b1, 7'h7F, 7'h00, 1'b1, 7'h00, 1'b1, 7'h00);
        step("mid_after", 1'b0, 7'h7F, 7'h00, 1'b1, 7'b0000001, 1'b1, 7'h00);
        for (int k = 0; k < 14; k++)
            step("age_clr", 1'b0, 7'b0011000, 7'b0010000, 1'b1, 7'b0010000, 1'b1, 7'h00);
        step("age_starve", 1'b0, 7'b0011000, 7'b0010000, 1'b1, 7'b0001000, 1'b1, 7'b0001000);

        // Random phase against the reference model, sticky requests to build starvation
        rq_r = 7'h7F;
        qs_r = 7'b0000111;
        for (int c = 0; c < 400; c++) begin
            logic         r;
            logic         rdy;
            logic [N-1:0] eg;
            logic [N-1:0] es;
            r   = (c == 0) || ($urandom_range(0, 63) == 0);
            rdy = ($urandom_range(0, 4) != 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 15) == 0) rq_r[i] = ~rq_r[i];
                if ($urandom_range(0, 31) == 0) qs_r[i] = ~qs_r[i];
            end
            eg = model_gnt(r, rq_r, qs_r, rdy);
            for (int i = 0; i < N; i++) es[i] = (m_age[i] == AGE_MAX);
            step("rand", r, rq_r, qs_r, rdy, eg, !r, es);
            model_update(r, rq_r, eg);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/out_port_sched.md
OUT_PORT_SCHED -- requirements
Module: out_port_sched

Interface
REQ-001 Parameter: N, default 7, number of requesters (input buffers A,Q,W,E,R,N,S feeding one output buffer).
REQ-002 Parameter: AGE_W, default 4, width of the per-requester starvation age counter.
REQ-003 Parameter: AGE_MAX, default 15, age value at which a requester is marked starved; SHALL be at most 2^AGE_W-1.
REQ-004 Port: clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 Port: rst  input  1  reset, synchronous and active-high; one clock, no other reset.
REQ-006 Port: req  input  N  per-requester request; bit i means input buffer i holds a packet routed to this output.
REQ-007 Port: qos  input  N  per-requester QoS bit; 1 means high priority; ignored where req[i]=0.
REQ-008 Port: out_rdy  input  1  output buffer can accept a packet this cycle.
REQ-009 Port: gnt  output  N  one-hot grant; drives the payload mux select and the input-buffer pop.
REQ-010 Port: gnt_vld  output  1  transfer this cycle; equals OR of gnt.
REQ-011 Port: gnt_idx  output  clog2(N)  binary index of the granted requester; 0 when gnt_vld=0.
REQ-012 Port: starved  output  N  bit i=1 when age[i]==AGE_MAX.

Function
REQ-013 Grant decision SHALL be combinational from req, qos, out_rdy and registered state, giving zero-cycle arbitration latency.
REQ-014 When out_rdy=0, rst=1 or req=0, gnt SHALL be all-zero and gnt_vld=0.
REQ-015 Candidates SHALL fall into three classes, highest first: starved, non-starved with qos=1, non-starved with qos=0.
REQ-016 The winner SHALL come from the highest non-empty class only.
REQ-017 Within a class, the winner SHALL be the first requesting index at or after rr_ptr, searching upward with wrap-around from N-1 to 0.
REQ-018 At most one gnt bit SHALL be set in any cycle.
REQ-019 rr_ptr (clog2(N) bits) SHALL update only on a transfer (gnt_vld=1), to the winner index +1, wrapping from N-1 to 0 (never reaching N).
REQ-020 rr_ptr SHALL hold when there is no transfer.
REQ-021 A single rr_ptr SHALL be shared by all classes.
REQ-022 Per-requester age[i] (AGE_W bits) SHALL update, by priority:
  - to 0 when req[i]=0;
  - to 0 when gnt[i]=1;
  - to age[i]+1, saturating at AGE_MAX, when req[i]=1, gnt_vld=1 and gnt[i]=0;
  - otherwise hold.
REQ-023 Age SHALL NOT advance while out_rdy=0; back-pressure does not count as losing arbitration.
REQ-024 Age SHALL advance regardless of qos[i], so high-QoS requesters losing to starved ones also age.
REQ-025 starved[i] SHALL be derived from the registered age; a requester reaching AGE_MAX at an edge is a starved candidate in the following cycle.
REQ-026 When simultaneous starved requesters exist, they SHALL be served in round-robin per REQ-017; each returns to age 0 when served.
REQ-027 A requester that drops req while starved SHALL leave the starved class on the next cycle, with age cleared.
REQ-028 The block SHALL hold no packet state; a grant is a one-cycle pop, and the requester re-requests for each packet.

Reset
REQ-029 While rst=1, gnt=0, gnt_vld=0 and gnt_idx=0 in the same cycle (combinationally gated).
REQ-030 At the first clock edge with rst=1, rr_ptr=0, all age=0 and starved=0.
REQ-031 Reset asserted mid-operation SHALL discard all age and pointer history; the first cycle after rst deasserts behaves as if out of power-on reset.

Verification
REQ-032 Reset, then req=7'b1000001, qos=0, out_rdy=1: gnt=0000001, idx=0; next cycle gnt=1000000, idx=6; then rr_ptr wraps to 0 and bit 0 wins again.
REQ-033 Class priority: req=7'b0000111, qos=7'b0000100, out_rdy=1 held: bit 2 granted every cycle.
REQ-034 Starvation, continuing REQ-033:
  - age[0] and age[1] reach 15 after 15 transfers; starved=0000011 the next cycle.
  - Bits 0 and 1 are then granted on consecutive cycles, ahead of bit 2.
  - Each age clears to 0 when that bit is served.
REQ-035 Back-pressure: req=1111111, out_rdy=0 for 20 cycles: gnt=0 throughout; ages and rr_ptr unchanged; on out_rdy=1 the grant goes to index rr_ptr.
REQ-036 Reset mid-run: with age[3]=9 and rr_ptr=5, pulse rst for 1 cycle: gnt=0 during rst; afterwards age=0, rr_ptr=0, and req=1111111 grants index 0.
REQ-037 Bench SHALL continuously check:
  - gnt is one-hot or zero;
  - gnt_vld == OR of gnt;
  - gnt never set where req=0;
  - gnt=0 whenever out_rdy=0;
  - no requester holding req with out_rdy=1 waits more than N*(AGE_MAX+1) cycles.
